// File: rtl/note_sequencer.sv
// Walks a song's note table in an external synchronous ROM and plays one note at a time.
// Define NOTE_SEQUENCER_LOOP_EN to make songs repeat instead of stopping at their end.
module note_sequencer #(
    parameter int STEP_W         = 5,
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 4,
    parameter int TICKS_PER_UNIT = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              select,
    output logic [STEP_W+1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    busy,
    output logic                    done
);

    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        FINISH
    } state_t;

    state_t              r_state;
    logic [1:0]          r_song;
    logic [STEP_W-1:0]   r_step;
    logic [DUR_W-1:0]    r_units;
    logic [TICK_W-1:0]   r_tick;
    logic [NOTE_W-1:0]   r_note;
    logic                r_busy;
    logic                r_done;

    logic [DUR_W-1:0]    w_romDur;
    logic [NOTE_W-1:0]   w_romNote;

    assign w_romDur  = rom_data[NOTE_W+DUR_W-1:NOTE_W];
    assign w_romNote = rom_data[NOTE_W-1:0];

    assign rom_addr = {r_song, r_step};
    assign note     = r_note;
    assign busy     = r_busy;
    assign done     = r_done;

    // A start pulse overrides whatever is playing; the held note bridges the refetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_song  <= '0;
            r_step  <= '0;
            r_units <= '0;
            r_tick  <= '0;
            r_note  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_song  <= select;
                r_step  <= '0;
                r_busy  <= 1'b1;
                r_state <= FETCH;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_note <= '0;
                        r_busy <= 1'b0;
                    end
                    FETCH: begin
                        r_state <= LOAD;
                    end
                    LOAD: begin
                        if (w_romDur == '0) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                            // An empty song must stop, otherwise it would loop silently forever.
                            if (r_step != '0) begin
                                r_step  <= '0;
                                r_done  <= 1'b1;
                                r_state <= FETCH;
                            end else begin
                                r_note  <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= FINISH;
                            end
`else
                            r_note  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
`endif
                        end else begin
                            r_note  <= w_romNote;
                            r_units <= w_romDur;
                            r_tick  <= '0;
                            r_state <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (r_tick != TICK_LAST) begin
                            r_tick <= r_tick + TICK_W'(1);
                        end else if (r_units != DUR_W'(1)) begin
                            r_units <= r_units - DUR_W'(1);
                            r_tick  <= '0;
                        end else if (r_step == '1) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
                            r_step  <= '0;
                            r_done  <= 1'b1;
                            r_state <= FETCH;
`else
                            r_note  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
`endif
                        end else begin
                            r_step  <= r_step + STEP_W'(1);
                            r_state <= FETCH;
                        end
                    end
                    FINISH: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Downstream consumer of the current-music selector FSM (the block that drives `select[1:0]` and `start`).
- On a `start` pulse, latches the song index and walks that song's note table in an external synchronous ROM.
- Presents one note code at a time for a programmed number of time units, then stops at an end marker.
- Its `note` output feeds the tone generator.

Parameters:
- STEP_W, 5: width of the per-song step index; each song owns 2^STEP_W ROM words.
- NOTE_W, 6: note code width; code 0 means silence.
- DUR_W, 4: duration field width, in time units.
- TICKS_PER_UNIT, 1000: clk cycles per time unit; legal values are 1 or more.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse from the selector FSM; begins or restarts playback.
- select  input  2  song index; sampled only in the cycle where start=1.
- rom_addr  output  STEP_W+2  {song, step} address to the note ROM.
- rom_data  input  NOTE_W+DUR_W  ROM word {dur, note}; valid exactly one cycle after rom_addr is presented.
- note  output  NOTE_W  current note code; 0 = silence.
- busy  output  1  high while a song is playing.
- done  output  1  one-cycle pulse when a song finishes.

Behaviour:
- Reset values: all outputs 0; internal song, step, unit and tick counters 0; state IDLE. Reset wins over every other input in the same cycle, including start, and aborts playback mid-note.
- States: IDLE, FETCH, LOAD, PLAY, FINISH.
- IDLE:
  - note=0, busy=0.
  - start=1 → latch song<=select, step<=0, go to FETCH.
- FETCH:
  - rom_addr={song,step}; busy=1.
  - note holds its previous value (0 for the first note).
  - Next state: LOAD.
- LOAD:
  - Sample rom_data.
  - If dur==0 (end marker), go to FINISH; note is not updated.
  - Otherwise note<=rom_data note field, units<=dur, tick<=0, go to PLAY.
- PLAY:
  - tick counts 0..TICKS_PER_UNIT-1.
  - At tick terminal count with units>1: units--, tick<=0.
  - At tick terminal count with units==1:
    - step==all-ones → FINISH (table overflow counts as end of song).
    - Otherwise step++ and go to FETCH.
- FINISH: note<=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Timing:
  - start sampled at cycle t → FETCH at t+1, LOAD at t+2, first note visible at t+3.
  - Each note is held for dur×TICKS_PER_UNIT PLAY cycles plus 2 fetch/load cycles. During those 2 cycles the previous note stays on `note`, so there is no audible gap.
- rom_addr holds {song,step} in all states; it is 0 after reset.
- start in any non-IDLE state (including FINISH) restarts playback: latch the new select, step<=0, go to FETCH. No done pulse is issued for the aborted song.
- Changes on select while start=0 are ignored.
- A note code of 0 with dur≠0 is a rest: played normally with note=0.
- Counter widths: tick counter is $clog2(TICKS_PER_UNIT) bits, minimum 1. No arithmetic overflow is possible because units never underflows below 1 in PLAY.

Optional Feature:
- Macro: NOTE_SEQUENCER_LOOP_EN.
- Defined: an end marker or step overflow returns to FETCH with step<=0 of the same song instead of going to FINISH.
  - done pulses one cycle at each wrap; busy stays 1; note holds through the wrap.
  - An end marker at step 0 (empty song) still goes to FINISH, to avoid an infinite silent loop.
- Undefined: behaviour exactly as in Behaviour above.

Test Plan (TICKS_PER_UNIT=2, ROM model with 1-cycle read latency):
1. Song 1 = {(note 5, dur 2), (note 9, dur 1), end}; pulse start with select=01.
   - rom_addr=0x20 at t+1; note=5 from t+3 for 4+2 cycles; note=9 for 2+2 cycles.
   - Then note=0, done pulse exactly once, busy low.
2. Restart mid-note: while song 1 is on note 5, pulse start with select=10.
   - No done pulse; rom_addr=0x40 the next cycle; song 2's first note appears 3 cycles after start.
3. Empty song 3 (end marker at step 0): pulse start with select=11.
   - busy high for exactly 2 cycles, note stays 0, done pulses at t+3.
4. Song 0 with no end marker in all 32 steps, each entry dur 1.
   - All 32 notes play in order; done pulses after step 31; rom_addr never wraps into song 1.
5. Reset asserted during PLAY together with a start pulse: next cycle all outputs are 0 and state is IDLE. Toggling select with start=0 has no effect.
6. With NOTE_SEQUENCER_LOOP_EN defined, run scenario 1: note sequence 5,9,5,9… with one done pulse per wrap and busy held at 1.
